clefia_sbox_layer: RTL and testbench

//  Parametrised, pipelined CLEFIA S-box substitution layer: LANES bytes substituted per beat.
//  Per-beat mode selects the F0 pattern (S0/S1 alternating) or the F1 pattern (S1/S0 alternating).

---
 rtl/clefia_pkg.sv | 54 +++++
 rtl/clefia_sbox_lane.sv | 12 +
 rtl/clefia_sbox_layer.sv | 85 ++++++++
 tb/tb_clefia_sbox_layer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clefia_pkg.sv
// CLEFIA S-box tables and lookup helpers shared by the substitution layer.
// Row r of each table holds entries 16*r .. 16*r+15, first entry in the most significant byte.
package clefia_pkg;

  localparam logic FSEL_F0 = 1'b0;
  localparam logic FSEL_F1 = 1'b1;

  localparam logic [0:255][7:0] S0_TABLE = {
    128'h5749d1c62f3374fb956d82ea0eb0a81c,
    128'h28d04b925cee85b1c40a763d63f917af,
    128'hbfa11965f77a322006cee4839d5b4cd8,
    128'h425d2ee8d49b0f133c8967c071aab6f5,
    128'ha4befd8c120097da78e1cf6b39435526,
    128'h3098ccddeb54b38f4e16fa22a5770961,
    128'hd62a533745c16caeef7008998b1df2b4,
    128'he9c79f4a3125fe7cd3a2bd561488600b,
    128'hcde234509edc11052bb7a948ff668a73,
    128'h037586f16aa740c2b92cdb1f58943eed,
    128'hfc1ba004b88de6596293357eca21df47,
    128'h15f3ba7fa669c84d873b9c01e0de2452,
    128'h7b0c681e80b25ae7add523f4463f91c9,
    128'h6e8472bb0d18d996f05f41ac27c5e33a,
    128'h816f07a379f62d381a445eb5d2eccb90,
    128'h9a36e529c34fab6451f810d7bc027d8e
  };

  localparam logic [0:255][7:0] S1_TABLE = {
    128'h6cdac3e94e9d0a3db836b43813340cd9,
    128'hbf74948fb79ce5dc9e07494f982cb093,
    128'h12ebcdb392e74160e321273be619d20e,
    128'h9111c73f2a8ea1bc2bc8c50f5bf3878b,
    128'hfbf5de20c6a784ced86551c9a4ef4353,
    128'h255d9b31e83e0dd780ff698aba0b735c,
    128'h6e541562f6353052a316d32832faaa5e,
    128'hcfeaed783358097b63c0c1461edfa999,
    128'h5504c486397782ec4018909759dd831f,
    128'h9a370624647ca556480885d06126ca6f,
    128'h7e6ab671a07005d1458c231cf0ee89ad,
    128'h7a4bc22fdb5a4d7667172df4cbb14aa8,
    128'hb522473ad5104c72cc00f9e0fde2feae,
    128'hf85fabf11b4281d6be4429a657b9aff2,
    128'hd47566bb689f5002013c7f8d1a88bdac,
    128'hf7e47996a2fc6db26b03e12e7d14951d
  };

  function automatic logic [7:0] clefia_s0(input logic [7:0] b);
    return S0_TABLE[b];
  endfunction

  function automatic logic [7:0] clefia_s1(input logic [7:0] b);
    return S1_TABLE[b];
  endfunction

endpackage

// File: rtl/clefia_sbox_lane.sv
// One byte lane of the substitution layer: sel=0 applies S0, sel=1 applies S1.
module clefia_sbox_lane
  import clefia_pkg::*;
(
  input  logic [7:0] din,
  input  logic       sel,
  output logic [7:0] dout
);

  assign dout = sel ? clefia_s1(din) : clefia_s0(din);

endmodule

// File: rtl/clefia_sbox_layer.sv
// Pipelined CLEFIA S-box layer: input stage register, combinational lookup, optional
// output register, with a bubble-free valid/ready chain so the round datapath can stall it.
module clefia_sbox_layer
  import clefia_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned OUT_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_fsel,
  input  logic [8*LANES-1:0] din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] dout,
  output logic               busy
);

  localparam int unsigned W = 8 * LANES;

  logic         s1_valid;
  logic         s1_fsel;
  logic [W-1:0] s1_data;
  logic         s2_valid;
  logic         next_ready;
  logic [W-1:0] lookup;

  assign in_ready = !s1_valid || next_ready;
  assign busy     = s1_valid | s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_fsel  <= 1'b0;
      s1_data  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fsel <= in_fsel;
        s1_data <= din;
      end
    end
  end

  // Odd lanes take S0 in the F0 pattern and S1 in the F1 pattern; even lanes the opposite.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic LANE_ODD = 1'(i % 2);
    clefia_sbox_lane u_lane (
      .din  (s1_data[8*i +: 8]),
      .sel  (s1_fsel ^ ~LANE_ODD),
      .dout (lookup[8*i +: 8])
    );
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic         s2_ready;
    logic [W-1:0] s2_data;

    assign s2_ready   = !s2_valid || out_ready;
    assign next_ready = s2_ready;
    assign out_valid  = s2_valid;
    assign dout       = s2_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= lookup;
        end
      end
    end
  end else begin : g_out_comb
    assign s2_valid   = 1'b0;
    assign next_ready = out_ready;
    assign out_valid  = s1_valid;
    // The lookup of a cleared stage register is not zero, so gate it to keep dout idle at 0.
    assign dout       = s1_valid ? lookup : '0;
  end

endmodule

// File: tb/tb_clefia_sbox_layer.sv
// Bench for clefia_sbox_layer: three configurations driven together, each scored against a
// table-driven lane model through its own expected-output queue.
module tb_clefia_sbox_layer;

  localparam logic [2047:0] TB_S0 = {
    128'h5749d1c62f3374fb956d82ea0eb0a81c, 128'h28d04b925cee85b1c40a763d63f917af,
    128'hbfa11965f77a322006cee4839d5b4cd8, 128'h425d2ee8d49b0f133c8967c071aab6f5,
    128'ha4befd8c120097da78e1cf6b39435526, 128'h3098ccddeb54b38f4e16fa22a5770961,
    128'hd62a533745c16caeef7008998b1df2b4, 128'he9c79f4a3125fe7cd3a2bd561488600b,
    128'hcde234509edc11052bb7a948ff668a73, 128'h037586f16aa740c2b92cdb1f58943eed,
    128'hfc1ba004b88de6596293357eca21df47, 128'h15f3ba7fa669c84d873b9c01e0de2452,
    128'h7b0c681e80b25ae7add523f4463f91c9, 128'h6e8472bb0d18d996f05f41ac27c5e33a,
    128'h816f07a379f62d381a445eb5d2eccb90, 128'h9a36e529c34fab6451f810d7bc027d8e
  };
  localparam logic [2047:0] TB_S1 = {
    128'h6cdac3e94e9d0a3db836b43813340cd9, 128'hbf74948fb79ce5dc9e07494f982cb093,
    128'h12ebcdb392e74160e321273be619d20e, 128'h9111c73f2a8ea1bc2bc8c50f5bf3878b,
    128'hfbf5de20c6a784ced86551c9a4ef4353, 128'h255d9b31e83e0dd780ff698aba0b735c,
    128'h6e541562f6353052a316d32832faaa5e, 128'hcfeaed783358097b63c0c1461edfa999,
    128'h5504c486397782ec4018909759dd831f, 128'h9a370624647ca556480885d06126ca6f,
    128'h7e6ab671a07005d1458c231cf0ee89ad, 128'h7a4bc22fdb5a4d7667172df4cbb14aa8,
    128'hb522473ad5104c72cc00f9e0fde2feae, 128'hf85fabf11b4281d6be4429a657b9aff2,
    128'hd47566bb689f5002013c7f8d1a88bdac, 128'hf7e47996a2fc6db26b03e12e7d14951d
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_fsel;
  logic         out_ready;
  logic [127:0] din_w;

  logic        a_rdy, a_ov, a_busy;
  logic [31:0] a_dout;
  logic        b_rdy, b_ov, b_busy;
  logic [127:0] b_dout;
  logic        c_rdy, c_ov, c_busy;
  logic [15:0] c_dout;

  int checks = 0;
  int errors = 0;

  logic [127:0] qa[$];
  logic [127:0] qb[$];
  logic [127:0] qc[$];

  logic        sa_ov, sa_rdy, sa_fin, sa_fout;
  logic [31:0] sa_dout;

  always #5 clk = ~clk;

  clefia_sbox_layer #(.LANES(4), .OUT_REG(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .in_fsel(in_fsel),
    .din(din_w[31:0]), .out_valid(a_ov), .out_ready(out_ready), .dout(a_dout), .busy(a_busy)
  );
  clefia_sbox_layer #(.LANES(16), .OUT_REG(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy), .in_fsel(in_fsel),
    .din(din_w), .out_valid(b_ov), .out_ready(out_ready), .dout(b_dout), .busy(b_busy)
  );
  clefia_sbox_layer #(.LANES(2), .OUT_REG(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_rdy), .in_fsel(in_fsel),
    .din(din_w[15:0]), .out_valid(c_ov), .out_ready(out_ready), .dout(c_dout), .busy(c_busy)
  );

  function automatic logic [7:0] ref_s0(input logic [7:0] b);
    logic [2047:0] t = TB_S0;
    return t[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] ref_s1(input logic [7:0] b);
    logic [2047:0] t = TB_S1;
    return t[2047 - 8*int'(b) -: 8];
  endfunction

  // F0: odd lanes S0, even lanes S1; F1 swaps them.
  function automatic logic [127:0] model(input logic [127:0] d, input logic f, input int lanes);
    logic [127:0] r = '0;
    for (int i = 0; i < lanes; i++) begin
      if (((i % 2) == 1) != f) r[8*i +: 8] = ref_s0(d[8*i +: 8]);
      else r[8*i +: 8] = ref_s1(d[8*i +: 8]);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, score every DUT against its queue, then advance past the next edge.
  task automatic tick();
    #4;
    sa_ov = a_ov; sa_rdy = a_rdy; sa_dout = a_dout;
    sa_fin = in_valid && a_rdy; sa_fout = a_ov && out_ready;
    if (a_ov) begin
      if (qa.size() == 0) chk("a_spurious_out", 128'(a_ov), 128'(0));
      else begin
        chk("a_dout", 128'(a_dout), qa[0]);
        if (out_ready) void'(qa.pop_front());
      end
    end
    if (b_ov) begin
      if (qb.size() == 0) chk("b_spurious_out", 128'(b_ov), 128'(0));
      else begin
        chk("b_dout", b_dout, qb[0]);
        if (out_ready) void'(qb.pop_front());
      end
    end
    if (c_ov) begin
      if (qc.size() == 0) chk("c_spurious_out", 128'(c_ov), 128'(0));
      else begin
        chk("c_dout", 128'(c_dout), qc[0]);
        if (out_ready) void'(qc.pop_front());
      end
    end
    if (in_valid && a_rdy) qa.push_back(model(din_w, in_fsel, 4));
    if (in_valid && b_rdy) qb.push_back(model(din_w, in_fsel, 16));
    if (in_valid && c_rdy) qc.push_back(model(din_w, in_fsel, 2));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (qa.size() + qb.size() + qc.size()) != 0; i++) tick();
    chk({tag, "_left_a"}, 128'(qa.size()), 128'(0));
    chk({tag, "_left_b"}, 128'(qb.size()), 128'(0));
    chk({tag, "_left_c"}, 128'(qc.size()), 128'(0));
  endtask

  task automatic directed(input string tag, input logic [31:0] d, input logic f,
                          input logic [31:0] exp);
    in_valid = 1'b1; din_w = 128'(d); in_fsel = f; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_not_early"}, 128'(sa_ov), 128'(0));
    tick();
    chk({tag, "_valid"}, 128'(sa_ov), 128'(1));
    chk({tag, "_data"}, 128'(sa_dout), 128'(exp));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_a_ov"}, 128'(a_ov), 128'(0));
    chk({tag, "_a_dout"}, 128'(a_dout), 128'(0));
    chk({tag, "_a_rdy"}, 128'(a_rdy), 128'(1));
    chk({tag, "_a_busy"}, 128'(a_busy), 128'(0));
    chk({tag, "_b_ov"}, 128'(b_ov), 128'(0));
    chk({tag, "_b_dout"}, b_dout, 128'(0));
    chk({tag, "_b_busy"}, 128'(b_busy), 128'(0));
    chk({tag, "_c_ov"}, 128'(c_ov), 128'(0));
    chk({tag, "_c_busy"}, 128'(c_busy), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] beats [3];
    int outs;

    rst = 1'b1; in_valid = 1'b0; in_fsel = 1'b0; out_ready = 1'b1; din_w = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    check_idle("reset");
    @(posedge clk);
    #1;

    directed("f0_zero", 32'h00000000, 1'b0, 32'h576c576c);
    directed("f1_zero", 32'h00000000, 1'b1, 32'h6c576c57);
    directed("f0_4500", 32'h45004500, 1'b0, 32'h006c006c);
    drain("directed");

    // Back-to-back stream: 16 consecutive outputs, input never stalls.
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      din_w = {$urandom, $urandom, $urandom, $urandom};
      in_fsel = 1'($urandom);
      tick();
      if (i < 16) chk("b2b_in_ready", 128'(sa_rdy), 128'(1));
      if (i >= 2) chk("b2b_out_valid", 128'(sa_ov), 128'(1));
    end
    drain("b2b");

    // Stall: three beats offered while the sink is blocked.
    for (int k = 0; k < 3; k++) beats[k] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0; in_valid = 1'b1; in_fsel = 1'b0;
    din_w = beats[0];
    tick();
    chk("stall_acc1", 128'(sa_fin), 128'(1));
    din_w = beats[1];
    tick();
    chk("stall_acc2", 128'(sa_fin), 128'(1));
    din_w = beats[2];
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("stall_in_ready", 128'(sa_rdy), 128'(0));
      chk("stall_out_valid", 128'(sa_ov), 128'(1));
      chk("stall_hold", 128'(sa_dout), model(beats[0], 1'b0, 4));
    end
    out_ready = 1'b1;
    outs = 0;
    for (int j = 0; j < 10 && in_valid; j++) begin
      tick();
      if (sa_fout) outs++;
      if (sa_fin) in_valid = 1'b0;
    end
    chk("stall_third_accepted", 128'(in_valid), 128'(0));
    for (int j = 0; j < 10 && qa.size() != 0; j++) begin
      tick();
      if (sa_fout) outs++;
    end
    chk("stall_release_count", 128'(outs), 128'(3));
    drain("stall");

    // Reset with two beats in flight.
    in_valid = 1'b1; out_ready = 1'b1;
    din_w = {$urandom, $urandom, $urandom, $urandom};
    tick();
    din_w = {$urandom, $urandom, $urandom, $urandom};
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    #4;
    check_idle("post_rst");
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) tick();
    chk("post_rst_quiet", 128'(sa_ov), 128'(0));

    // Sweep every code through every lane for both patterns.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int code = 0; code < 256; code++) begin
        for (int i = 0; i < 16; i++) din_w[8*i +: 8] = 8'(code + 17 * i);
        in_fsel = 1'(f);
        tick();
      end
    end
    drain("sweep");

    // Random traffic with random back-pressure.
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_fsel = 1'($urandom);
      din_w = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
